// File: rtl/hls_deadlock_multi_monitor.sv
// Deadlock monitor for one HLS instance: trips when any AXIS or sub-instance block source
// persists for THRESHOLD consecutive cycles, records the tripping source and counts trips.
module hls_deadlock_multi_monitor #(
  parameter int N_AXIS    = 2,
  parameter int N_INST    = 2,
  parameter int THRESHOLD = 16,
  parameter int CNT_W     = 8,
  parameter int STICKY    = 0,
  parameter int EVT_W     = 16,
  parameter int SRC_W     = ((N_AXIS + N_INST) > 1) ? $clog2(N_AXIS + N_INST) : 1,
  localparam int INST_W   = (N_INST > 0) ? N_INST : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N_AXIS-1:0]  axis_block_sigs,
  input  logic [INST_W-1:0]  inst_idle_sigs,
  input  logic [INST_W-1:0]  inst_block_sigs,
  input  logic               clear,
  output logic               block,
  output logic [SRC_W-1:0]   block_src,
  output logic [EVT_W-1:0]   event_count
);

  localparam int N_SRC = N_AXIS + N_INST;
  localparam logic [CNT_W:0] THR = (CNT_W + 1)'(THRESHOLD);

  logic [N_SRC-1:0] srcs;
  logic             raw;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W:0]   cnt_inc;
  logic             trip;
  logic             block_next;
  logic             rise;
  logic [SRC_W-1:0] enc;

  // An idle sub-instance is waiting legitimately, so its block flag is masked off.
  generate
    if (N_INST > 0) begin : g_inst
      assign srcs = {inst_block_sigs & ~inst_idle_sigs, axis_block_sigs};
    end else begin : g_no_inst
      logic unused_inst;
      assign unused_inst = ^{inst_idle_sigs, inst_block_sigs};
      assign srcs = axis_block_sigs;
    end
  endgenerate

  assign raw        = |srcs;
  assign cnt_inc    = {1'b0, cnt} + (CNT_W + 1)'(1);
  assign trip       = raw & (cnt_inc >= THR);
  assign cnt_next   = !raw ? '0 : (cnt_inc >= THR) ? THR[CNT_W-1:0] : cnt_inc[CNT_W-1:0];
  assign block_next = (STICKY != 0) ? (block | trip) : trip;
  assign rise       = block_next & ~block;

  // Scan downward so the lowest-index active source is the one left in enc.
  always_comb begin
    enc = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (srcs[i]) enc = SRC_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt         <= '0;
      block       <= 1'b0;
      block_src   <= '0;
      event_count <= '0;
    end else if (clear) begin
      cnt         <= '0;
      block       <= 1'b0;
      block_src   <= '0;
      event_count <= '0;
    end else begin
      cnt   <= cnt_next;
      block <= block_next;
      // Source and event count are captured only on the rising edge of block.
      if (rise) begin
        block_src <= enc;
        if (event_count != {EVT_W{1'b1}}) event_count <= event_count + EVT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hls_deadlock_multi_monitor.sv
// Bench for hls_deadlock_multi_monitor: four configurations share one stimulus bus; each
// test checks the configuration it targets through an expected-value scoreboard.
module tb_hls_deadlock_multi_monitor;

  logic       clock;
  logic       reset_n;
  logic [1:0] axis_block_sigs;
  logic [1:0] inst_idle_sigs;
  logic [1:0] inst_block_sigs;
  logic       clear;

  logic        block0, block1, block2, block3;
  logic [1:0]  src0, src1, src2, src3;
  logic [15:0] evt0, evt1, evt2;
  logic [1:0]  evt3;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst_n;
    logic        clr;
    logic [1:0]  axis;
    logic [1:0]  idle;
    logic [1:0]  iblk;
    int          reps;
    logic        exp_block;
    logic [1:0]  exp_src;
    logic [15:0] exp_evt;
  } step_t;

  typedef struct {
    int          sel;
    logic        blk;
    logic [1:0]  src;
    logic [15:0] evt;
  } exp_t;

  step_t vec[$];
  exp_t  sb[$];

  hls_deadlock_multi_monitor #(.N_AXIS(2), .N_INST(2), .THRESHOLD(16), .CNT_W(8),
    .STICKY(0), .EVT_W(16)) dut_base (
    .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .clear(clear),
    .block(block0), .block_src(src0), .event_count(evt0));

  hls_deadlock_multi_monitor #(.N_AXIS(2), .N_INST(2), .THRESHOLD(16), .CNT_W(8),
    .STICKY(1), .EVT_W(16)) dut_sticky (
    .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .clear(clear),
    .block(block1), .block_src(src1), .event_count(evt1));

  hls_deadlock_multi_monitor #(.N_AXIS(2), .N_INST(2), .THRESHOLD(1), .CNT_W(8),
    .STICKY(0), .EVT_W(16)) dut_t1 (
    .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .clear(clear),
    .block(block2), .block_src(src2), .event_count(evt2));

  hls_deadlock_multi_monitor #(.N_AXIS(2), .N_INST(2), .THRESHOLD(3), .CNT_W(8),
    .STICKY(0), .EVT_W(2)) dut_evt2 (
    .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .clear(clear),
    .block(block3), .block_src(src3), .event_count(evt3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Holds one input pattern for reps cycles; the expectation applies after the last edge.
  task automatic apply_stimulus(input int sel, input logic rst, input logic clr,
                                input logic [1:0] ax, input logic [1:0] idl,
                                input logic [1:0] ib, input int reps, input logic eb,
                                input logic [1:0] es, input logic [15:0] ee);
    exp_t e;
    for (int r = 0; r < reps; r++) begin
      @(negedge clock);
      reset_n         = rst;
      clear           = clr;
      axis_block_sigs = ax;
      inst_idle_sigs  = idl;
      inst_block_sigs = ib;
      if (r == reps - 1) begin
        e.sel = sel;
        e.blk = eb;
        e.src = es;
        e.evt = ee;
        sb.push_back(e);
      end
      @(posedge clock);
    end
  endtask

  task automatic check_output(input string label);
    exp_t        e;
    logic        ab;
    logic [1:0]  as;
    logic [15:0] ae;
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: scoreboard empty, no expectation queued", label);
      return;
    end
    e = sb.pop_front();
    case (e.sel)
      0:       begin ab = block0; as = src0; ae = evt0; end
      1:       begin ab = block1; as = src1; ae = evt1; end
      2:       begin ab = block2; as = src2; ae = evt2; end
      default: begin ab = block3; as = src3; ae = {14'd0, evt3}; end
    endcase
    checks++;
    if (ab !== e.blk) begin
      errors++;
      $display("[TB] FAIL %s block: got %b expected %b", label, ab, e.blk);
    end
    checks++;
    if (as !== e.src) begin
      errors++;
      $display("[TB] FAIL %s block_src: got %0d expected %0d", label, as, e.src);
    end
    checks++;
    if (ae !== e.evt) begin
      errors++;
      $display("[TB] FAIL %s event_count: got %0d expected %0d", label, ae, e.evt);
    end
  endtask

  task automatic run(input int sel, input logic rst, input logic clr, input logic [1:0] ax,
                     input logic [1:0] idl, input logic [1:0] ib, input int reps,
                     input logic eb, input logic [1:0] es, input logic [15:0] ee,
                     input string label);
    apply_stimulus(sel, rst, clr, ax, idl, ib, reps, eb, es, ee);
    check_output(label);
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0;
    axis_block_sigs = '0; inst_idle_sigs = '0; inst_block_sigs = '0;

    // rst, clr, axis, idle, iblk, reps, block, src, evt   (THRESHOLD=16, non-sticky)
    vec.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 2'b00,  2, 1'b0, 2'd0, 16'd0});
    vec.push_back('{1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 15, 1'b0, 2'd0, 16'd0});
    vec.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 2'b00,  1, 1'b0, 2'd0, 16'd0});
    vec.push_back('{1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 15, 1'b0, 2'd0, 16'd0});
    vec.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 2'b00,  1, 1'b0, 2'd0, 16'd0});
    vec.push_back('{1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 15, 1'b0, 2'd0, 16'd0});
    vec.push_back('{1'b1, 1'b0, 2'b10, 2'b00, 2'b00,  1, 1'b1, 2'd1, 16'd1});
    vec.push_back('{1'b1, 1'b0, 2'b10, 2'b00, 2'b00,  4, 1'b1, 2'd1, 16'd1});
    vec.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 2'b00,  1, 1'b0, 2'd1, 16'd1});
    vec.push_back('{1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 15, 1'b0, 2'd1, 16'd1});
    vec.push_back('{1'b1, 1'b0, 2'b01, 2'b00, 2'b00,  1, 1'b1, 2'd0, 16'd2});
    vec.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 2'b00,  1, 1'b0, 2'd0, 16'd2});
    vec.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 15, 1'b0, 2'd0, 16'd2});
    vec.push_back('{1'b1, 1'b0, 2'b10, 2'b00, 2'b11,  1, 1'b1, 2'd1, 16'd3});
    vec.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 2'b00,  1, 1'b0, 2'd1, 16'd3});
    vec.push_back('{1'b1, 1'b0, 2'b00, 2'b10, 2'b10, 40, 1'b0, 2'd1, 16'd3});
    vec.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 15, 1'b0, 2'd1, 16'd3});
    vec.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 2'b10,  1, 1'b1, 2'd3, 16'd4});
    vec.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 2'b00,  1, 1'b0, 2'd3, 16'd4});
    vec.push_back('{1'b1, 1'b0, 2'b00, 2'b10, 2'b01, 16, 1'b1, 2'd2, 16'd5});
    vec.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 2'b00,  1, 1'b0, 2'd2, 16'd5});
    vec.push_back('{1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 10, 1'b0, 2'd2, 16'd5});
    vec.push_back('{1'b1, 1'b1, 2'b01, 2'b00, 2'b00,  1, 1'b0, 2'd0, 16'd0});
    vec.push_back('{1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 15, 1'b0, 2'd0, 16'd0});
    vec.push_back('{1'b1, 1'b0, 2'b01, 2'b00, 2'b00,  1, 1'b1, 2'd0, 16'd1});
    vec.push_back('{1'b1, 1'b1, 2'b01, 2'b00, 2'b00,  1, 1'b0, 2'd0, 16'd0});
    vec.push_back('{1'b1, 1'b0, 2'b01, 2'b00, 2'b00,  1, 1'b0, 2'd0, 16'd0});
    vec.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 2'b00,  1, 1'b0, 2'd0, 16'd0});
    vec.push_back('{1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 16, 1'b1, 2'd0, 16'd1});
    vec.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 2'b00,  1, 1'b0, 2'd0, 16'd1});
    vec.push_back('{1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 10, 1'b0, 2'd0, 16'd1});
    vec.push_back('{1'b0, 1'b0, 2'b01, 2'b00, 2'b00,  1, 1'b0, 2'd0, 16'd0});
    vec.push_back('{1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 15, 1'b0, 2'd0, 16'd0});
    vec.push_back('{1'b1, 1'b0, 2'b01, 2'b00, 2'b00,  1, 1'b1, 2'd0, 16'd1});
    vec.push_back('{1'b0, 1'b1, 2'b01, 2'b00, 2'b00,  1, 1'b0, 2'd0, 16'd0});

    for (int i = 0; i < vec.size(); i++) begin
      apply_stimulus(0, vec[i].rst_n, vec[i].clr, vec[i].axis, vec[i].idle, vec[i].iblk,
                     vec[i].reps, vec[i].exp_block, vec[i].exp_src, vec[i].exp_evt);
      check_output($sformatf("base_vec%0d", i));
    end

    // Sticky: block survives idle sources and only clear drops it.
    run(1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00,  2, 1'b0, 2'd0, 16'd0, "sticky_reset");
    run(1, 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 16, 1'b1, 2'd1, 16'd1, "sticky_trip");
    run(1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 10, 1'b1, 2'd1, 16'd1, "sticky_hold");
    run(1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 20, 1'b1, 2'd1, 16'd1, "sticky_no_retrip");
    run(1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00,  1, 1'b0, 2'd0, 16'd0, "sticky_clear");
    run(1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 16, 1'b1, 2'd0, 16'd1, "sticky_retrip");

    // THRESHOLD=1: one-cycle registered follow, clear beats trip, src holds after fall.
    run(2, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00,  2, 1'b0, 2'd0, 16'd0, "t1_reset");
    run(2, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00,  1, 1'b1, 2'd0, 16'd1, "t1_up1");
    run(2, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00,  1, 1'b0, 2'd0, 16'd1, "t1_down1");
    run(2, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00,  1, 1'b1, 2'd0, 16'd2, "t1_up2");
    run(2, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00,  1, 1'b0, 2'd0, 16'd2, "t1_down2");
    run(2, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00,  1, 1'b0, 2'd0, 16'd0, "t1_clear_vs_trip");
    run(2, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00,  1, 1'b1, 2'd0, 16'd1, "t1_after_clear");
    run(2, 1'b1, 1'b0, 2'b00, 2'b11, 2'b11,  1, 1'b0, 2'd0, 16'd1, "t1_idle_masked");
    run(2, 1'b1, 1'b0, 2'b00, 2'b01, 2'b11,  1, 1'b1, 2'd3, 16'd2, "t1_inst1_src");
    run(2, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00,  1, 1'b1, 2'd3, 16'd2, "t1_src_held");
    run(2, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00,  1, 1'b0, 2'd3, 16'd2, "t1_src_after_fall");
    run(2, 1'b1, 1'b0, 2'b11, 2'b00, 2'b11,  1, 1'b1, 2'd0, 16'd3, "t1_priority");

    // EVT_W=2, THRESHOLD=3: event counter saturates at 3.
    run(3, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00,  2, 1'b0, 2'd0, 16'd0, "evt_reset");
    run(3, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00,  2, 1'b0, 2'd0, 16'd0, "evt_short");
    run(3, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00,  1, 1'b0, 2'd0, 16'd0, "evt_gap");
    for (int k = 1; k <= 5; k++) begin
      run(3, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 3, 1'b1, 2'd0, 16'((k > 3) ? 3 : k),
          $sformatf("evt_trip%0d", k));
      run(3, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1, 1'b0, 2'd0, 16'((k > 3) ? 3 : k),
          $sformatf("evt_fall%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
